tone_sequencer: RTL and testbench

- Upstream source for the Audio_Controller output path. Steps through a song ROM of note entries, each holding a half-period and a duration.
- Synthesises a square-wave tone at tempo-driven note boundaries.
- Pushes 32-bit left/right samples at a fixed 48 kHz rate through the controller's audio_out_allowed / write_audio_out handshake.
- Replaces the free-running delay counter in the top level with a sequenced, rate-limited sample producer.

---
 rtl/tone_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_tone_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_sequencer.sv
// Song-ROM driven square-wave tone generator feeding the Audio_Controller
// write handshake with a fixed-rate, rate-limited sample stream.
module tone_sequencer #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned HP_W        = 18,
  parameter int unsigned DUR_W       = 8,
  parameter int unsigned LAST_ADDR   = 729,
  parameter int unsigned BEAT_CYCLES = 3125000,
  parameter int unsigned SAMPLE_DIV  = 1042,
  parameter int unsigned AMPLITUDE   = 10000000
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic                   play,
  input  logic                   stop,
  input  logic                   loop_en,
  output logic [ADDR_W-1:0]      rom_addr,
  input  logic [DUR_W+HP_W-1:0]  rom_q,
  input  logic                   audio_out_allowed,
  output logic                   write_audio_out,
  output logic [31:0]            left_channel_audio_out,
  output logic [31:0]            right_channel_audio_out,
  output logic                   busy,
  output logic [ADDR_W-1:0]      note_index
);

  localparam int unsigned BEAT_W = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
  localparam int unsigned DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [BEAT_W-1:0] BEAT_MAX  = BEAT_W'(BEAT_CYCLES - 1);
  localparam logic [DIV_W-1:0]  DIV_MAX   = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(LAST_ADDR);
  localparam logic [31:0]       AMP_POS   = 32'(AMPLITUDE);
  localparam logic [31:0]       AMP_NEG   = ~AMP_POS + 32'd1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_LOAD,
    S_PLAY,
    S_END
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   note_q, note_d;
  logic [DUR_W-1:0]    dur_q, dur_d;
  logic [HP_W-1:0]     hp_q, hp_d;
  logic [HP_W-1:0]     tone_q, tone_d;
  logic                phase_q, phase_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [DUR_W-1:0]    ticks_q, ticks_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [31:0]         sample_q, sample_d;
  logic                pending_q, pending_d;
  logic                strobe;
  logic [31:0]         tone_val;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    note_d    = note_q;
    dur_d     = dur_q;
    hp_d      = hp_q;
    tone_d    = tone_q;
    phase_d   = phase_q;
    beat_d    = beat_q;
    ticks_d   = ticks_q;
    sample_d  = sample_q;
    pending_d = pending_q;

    strobe = (div_q == DIV_MAX);
    div_d  = strobe ? '0 : div_q + DIV_W'(1);

    tone_val = '0;
    if (state_q == S_PLAY && hp_q != '0) begin
      tone_val = phase_q ? AMP_POS : AMP_NEG;
    end

    // A strobe replaces any unwritten sample; otherwise a granted write retires it.
    if (strobe) begin
      sample_d  = tone_val;
      pending_d = 1'b1;
    end else if (pending_q && audio_out_allowed) begin
      pending_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (play && !stop) begin
          state_d = S_FETCH;
          addr_d  = '0;
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT:  state_d = S_LOAD;
      S_LOAD: begin
        dur_d  = rom_q[DUR_W+HP_W-1:HP_W];
        hp_d   = rom_q[HP_W-1:0];
        note_d = addr_q;
        if (rom_q[DUR_W+HP_W-1:HP_W] == '0) begin
          state_d = S_END;
        end else begin
          tone_d  = '0;
          phase_d = 1'b0;
          beat_d  = '0;
          ticks_d = '0;
          state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        if (ticks_q == dur_q) begin
          if (addr_q == ADDR_LAST) begin
            state_d = S_END;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = S_FETCH;
          end
        end else begin
          // hp == 0 keeps the counter pinned at zero and the phase frozen (rest).
          if (tone_q == hp_q) begin
            tone_d = '0;
            if (hp_q != '0) phase_d = ~phase_q;
          end else begin
            tone_d = tone_q + HP_W'(1);
          end
          if (beat_q == BEAT_MAX) begin
            beat_d  = '0;
            ticks_d = ticks_q + DUR_W'(1);
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      S_END: begin
        if (loop_en) begin
          addr_d  = '0;
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (stop && state_q != S_IDLE) begin
      state_d   = S_IDLE;
      sample_d  = '0;
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      note_q    <= '0;
      dur_q     <= '0;
      hp_q      <= '0;
      tone_q    <= '0;
      phase_q   <= 1'b0;
      beat_q    <= '0;
      ticks_q   <= '0;
      div_q     <= '0;
      sample_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      note_q    <= note_d;
      dur_q     <= dur_d;
      hp_q      <= hp_d;
      tone_q    <= tone_d;
      phase_q   <= phase_d;
      beat_q    <= beat_d;
      ticks_q   <= ticks_d;
      div_q     <= div_d;
      sample_q  <= sample_d;
      pending_q <= pending_d;
    end
  end

  assign rom_addr                = addr_q;
  assign note_index              = note_q;
  assign busy                    = (state_q != S_IDLE);
  assign write_audio_out         = pending_q & audio_out_allowed;
  assign left_channel_audio_out  = sample_q;
  assign right_channel_audio_out = sample_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Randomised scoreboard bench for tone_sequencer: a note-schedule model predicts
// busy, note_index and every sample written through the audio handshake.
module tb_tone_sequencer;

  localparam int ADDR_W  = 10;
  localparam int HP_W    = 18;
  localparam int DUR_W   = 8;
  localparam int TB_LAST = 7;
  localparam int TB_BEAT = 40;
  localparam int TB_DIV  = 13;
  localparam int AMP     = 10000000;
  localparam int HORIZON = 6000;
  localparam int INF     = 1 << 30;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  play = 1'b0;
  logic                  stop = 1'b0;
  logic                  loop_en = 1'b0;
  logic [ADDR_W-1:0]     rom_addr;
  logic [DUR_W+HP_W-1:0] rom_q = '0;
  logic                  audio_out_allowed = 1'b1;
  logic                  write_audio_out;
  logic [31:0]           left_out, right_out;
  logic                  busy;
  logic [ADDR_W-1:0]     note_index;

  logic [DUR_W+HP_W-1:0] rom [0:(1<<ADDR_W)-1];

  int vectors = 0;
  int miscompares = 0;
  bit rand_allow = 1'b0;

  // model state: planned PLAY segments in cycle numbers since the last reset
  int cyc = 0;
  bit armed = 1'b0;
  bit plan_active = 1'b0;
  int plan_p = 0;
  int idle_from = INF;
  int seg_start[$];
  int seg_end[$];
  int seg_hp[$];
  int seg_addr[$];
  int exp_q[$];

  tone_sequencer #(
    .ADDR_W(ADDR_W), .HP_W(HP_W), .DUR_W(DUR_W), .LAST_ADDR(TB_LAST),
    .BEAT_CYCLES(TB_BEAT), .SAMPLE_DIV(TB_DIV), .AMPLITUDE(AMP)
  ) dut (
    .CLOCK_50(clk), .reset(reset), .play(play), .stop(stop), .loop_en(loop_en),
    .rom_addr(rom_addr), .rom_q(rom_q), .audio_out_allowed(audio_out_allowed),
    .write_audio_out(write_audio_out), .left_channel_audio_out(left_out),
    .right_channel_audio_out(right_out), .busy(busy), .note_index(note_index)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_q <= rom[rom_addr];

  function automatic int find_seg(input int c);
    if (!plan_active || c >= idle_from) return -1;
    for (int i = 0; i < seg_start.size(); i++)
      if (c >= seg_start[i] && c <= seg_end[i]) return i;
    return -1;
  endfunction

  function automatic int level_at(input int c);
    int k;
    k = find_seg(c);
    if (k < 0 || seg_hp[k] == 0) return 0;
    return (((c - seg_start[k]) / (seg_hp[k] + 1)) % 2 == 1) ? AMP : -AMP;
  endfunction

  function automatic bit busy_at(input int c);
    return plan_active && c >= plan_p && c < idle_from;
  endfunction

  // FETCH of an entry at cycle t: PLAY spans t+3 .. t+3+dur*BEAT, next FETCH after one more.
  task automatic build_plan(input int p, input bit lp);
    int t, a, d, h;
    logic [DUR_W+HP_W-1:0] e;
    seg_start.delete(); seg_end.delete(); seg_hp.delete(); seg_addr.delete();
    plan_active = 1'b1;
    plan_p = p;
    idle_from = INF;
    t = p;
    a = 0;
    while (t < p + HORIZON) begin
      e = rom[a];
      d = int'(e[DUR_W+HP_W-1:HP_W]);
      h = int'(e[HP_W-1:0]);
      if (d == 0) begin
        if (lp) begin t = t + 4; a = 0; end
        else begin idle_from = t + 4; break; end
      end else begin
        seg_start.push_back(t + 3);
        seg_end.push_back(t + 3 + d * TB_BEAT);
        seg_hp.push_back(h);
        seg_addr.push_back(a);
        if (a == TB_LAST) begin
          if (lp) begin t = t + 5 + d * TB_BEAT; a = 0; end
          else begin idle_from = t + 5 + d * TB_BEAT; break; end
        end else begin
          t = t + 4 + d * TB_BEAT;
          a = a + 1;
        end
      end
    end
  endtask

  // reference model: advances once per clock edge using the inputs of the cycle just ending
  always @(posedge clk) begin
    int c;
    bit bsy;
    if (reset) begin
      exp_q.delete();
      cyc = 0;
      plan_active = 1'b0;
      idle_from = INF;
      armed = 1'b1;
    end else if (armed) begin
      c = cyc;
      bsy = busy_at(c);
      if (stop && bsy) begin
        exp_q.delete();
        idle_from = c + 1;
      end else begin
        if ((c + 1) % TB_DIV == 0) begin
          exp_q.delete();
          exp_q.push_back(level_at(c));
        end
        if (!bsy && play) build_plan(c + 1, loop_en);
      end
      cyc = c + 1;
    end
  end

  // monitor: compares every cycle away from the active edge
  always @(negedge clk) begin
    int c, k;
    logic exp_w;
    logic [31:0] exp_s;
    if (armed) begin
      c = cyc;
      exp_w = (exp_q.size() > 0) && audio_out_allowed;
      vectors++;
      if (write_audio_out !== exp_w) begin
        miscompares++;
        $display("FAIL write_strobe cycle %0d: got %b expected %b", c, write_audio_out, exp_w);
      end
      if (write_audio_out === 1'b1 && exp_q.size() > 0) begin
        exp_s = 32'(exp_q.pop_front());
        vectors++;
        if (left_out !== exp_s || right_out !== exp_s) begin
          miscompares++;
          $display("FAIL sample cycle %0d: got L=%0d R=%0d expected %0d",
                   c, $signed(left_out), $signed(right_out), $signed(exp_s));
        end
      end
      vectors++;
      if (busy !== busy_at(c)) begin
        miscompares++;
        $display("FAIL busy cycle %0d: got %b expected %b", c, busy, busy_at(c));
      end
      k = find_seg(c);
      if (k >= 0) begin
        vectors++;
        if (note_index !== ADDR_W'(seg_addr[k])) begin
          miscompares++;
          $display("FAIL note_index cycle %0d: got %0d expected %0d", c, note_index, seg_addr[k]);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      if (rand_allow) audio_out_allowed = ($urandom % 4) != 0;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_rom(input int a, input int d, input int h);
    rom[a] = {DUR_W'(d), HP_W'(h)};
  endtask

  task automatic clear_rom();
    for (int i = 0; i < (1 << ADDR_W); i++) rom[i] = '0;
  endtask

  task automatic pulse(input int which);
    if (which == 0) play = 1'b1; else if (which == 1) stop = 1'b1; else reset = 1'b1;
    step(1);
    play = 1'b0; stop = 1'b0; reset = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int k;
    k = 0;
    while (busy === 1'b1 && k < limit) begin
      step(1);
      k++;
    end
    vectors++;
    if (k >= limit) begin
      miscompares++;
      $display("FAIL idle_timeout: still busy after %0d cycles, required idle", limit);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog");
  end

  initial begin
    clear_rom();
    step(3);
    reset = 1'b0;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_note_index", 32'(note_index), 32'd0);
    check("reset_rom_addr", 32'(rom_addr), 32'd0);
    check("reset_write", 32'(write_audio_out), 32'd0);

    // idle streaming of zero samples
    step(5 * TB_DIV);

    // single note then end marker, no loop
    set_rom(0, 2, 9);
    set_rom(1, 0, 0);
    loop_en = 1'b0;
    pulse(0);
    wait_idle(400);
    step(30);

    // same song looping, then stopped
    loop_en = 1'b1;
    pulse(0);
    step(500);
    pulse(1);
    step(30);
    loop_en = 1'b0;

    // rest note followed by a tone; a second play mid-song is ignored
    set_rom(0, 1, 0);
    set_rom(1, 2, 4);
    set_rom(2, 0, 0);
    pulse(0);
    step(60);
    pulse(0);
    wait_idle(400);
    step(20);

    // back-pressure across three strobes
    set_rom(0, 3, 6);
    set_rom(1, 0, 0);
    pulse(0);
    step(10);
    audio_out_allowed = 1'b0;
    step(3 * TB_DIV + 4);
    audio_out_allowed = 1'b1;
    wait_idle(400);
    step(20);

    // stop mid-note, then reset mid-note
    set_rom(0, 3, 5);
    set_rom(1, 3, 7);
    set_rom(2, 0, 0);
    pulse(0);
    step(60);
    pulse(1);
    step(20);
    pulse(0);
    step(170);
    pulse(2);
    check("reset_mid_note_index", 32'(note_index), 32'd0);
    check("reset_mid_busy", 32'(busy), 32'd0);
    check("reset_mid_rom_addr", 32'(rom_addr), 32'd0);
    step(3 * TB_DIV);

    // randomised songs, flow control and abort paths
    for (int it = 0; it < 10; it++) begin
      int act;
      clear_rom();
      for (int a = 0; a <= TB_LAST; a++) begin
        int d, h;
        d = (($urandom % 7) == 0) ? 0 : int'($urandom_range(1, 3));
        h = (($urandom % 4) == 0) ? 0 : int'($urandom_range(1, 20));
        set_rom(a, d, h);
      end
      loop_en = ($urandom % 3) == 0;
      rand_allow = 1'b1;
      pulse(0);
      act = $urandom % 3;
      if (loop_en && act == 0) act = 1;
      if (act == 0) begin
        step(int'($urandom_range(1, 200)));
        pulse(0);
        wait_idle(2500);
      end else begin
        step(int'($urandom_range(1, 400)));
        pulse(act);
      end
      step(int'($urandom_range(5, 40)));
      rand_allow = 1'b0;
      audio_out_allowed = 1'b1;
      loop_en = 1'b0;
      step(2);
    end

    step(40);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
